if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the IF/ID segment register.
- Owns the PC and issues single-outstanding requests to the instruction memory over a request/valid handshake.
- Buffers one returned instruction while IF/ID is stalled, and applies branch/jump redirects from EX.
- Squashes any in-flight fetch that a redirect makes stale.

Parameters:
- RESET_PC, 32'h0000_3000, PC after reset.
- BUBBLE_INST, 32'h0000_0000, instruction driven on inst_out when if_valid=0; matches the IF/ID flush value.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- im_req  out  1  fetch request; held high until the im_rvalid cycle, inclusive.
- im_addr  out  32  fetch address; stable while im_req=1.
- im_rdata  in  32  returned instruction; sampled only when im_rvalid=1.
- im_rvalid  in  1  single-cycle response pulse, at least 1 cycle after the request's first cycle.
- stall  in  1  IF/ID stall from the hazard unit; IF/ID does not capture this cycle.
- redirect  in  1  EX taken-branch/jal/jalr.
- redirect_pc  in  32  target PC; bits [1:0] are ignored and forced to 0.
- pc_cur_out  out  32  PC of the presented instruction; 0 when if_valid=0.
- pc_add4_out  out  32  pc_cur_out+4; RESET_PC when if_valid=0.
- inst_out  out  32  presented instruction.
- if_valid  out  1  instruction presented this cycle; feeds IF/ID im_rvalid_in.
- if_busy  out  1  equals !if_valid; the hazard unit flushes IF/ID on this.

Behaviour:
- Reset (async): state=WAIT, pc=RESET_PC, buffer cleared, im_req=0 while rst=1.
  - Outputs during reset: if_valid=0, inst_out=BUBBLE_INST, pc_cur_out=0, pc_add4_out=RESET_PC.
  - The instruction memory shares rst, so no stale response survives a reset.
- States: WAIT (request outstanding for pc), HOLD (instruction buffered, waiting for accept), KILL (stale request outstanding, response to be discarded).
- WAIT:
  - Outputs: im_req=1, im_addr=pc.
  - If im_rvalid=1 and redirect=0: if_valid=1 this cycle, and inst_out=im_rdata is bypassed combinationally.
    - With stall=0: accepted. pc<=pc+4, stay WAIT, and the new request goes out next cycle.
    - With stall=1: buffer<=im_rdata, go HOLD.
  - No im_rvalid: stay WAIT.
- HOLD:
  - Outputs: im_req=0, if_valid=1, inst_out=buffer.
  - stall=0: pc<=pc+4, go WAIT.
  - stall=1: hold all state.
- KILL:
  - Outputs: im_req=1, im_addr=the stale address (held in a separate register), if_valid=0.
  - On im_rvalid: discard the data and go WAIT with the current pc.
- Redirect (highest priority, independent of stall): if_valid is forced to 0 in the redirect cycle, and pc<=redirect_pc.
  - WAIT without im_rvalid: go KILL.
  - WAIT with im_rvalid: data discarded, go WAIT; the new request goes out next cycle.
  - HOLD: buffer dropped, go WAIT.
  - KILL without im_rvalid: stay KILL with the latest target.
  - KILL with im_rvalid: go WAIT.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Throughput:
  - 1-cycle memory latency: one instruction every 2 cycles.
  - Redirect penalty: cycles to next valid = remaining stale latency + full new latency.
- if_valid only ever depends on state, im_rvalid and redirect, never on stall. This prevents a combinational loop with the hazard unit.

Decomposition:
- Package if_pkg holds:
  - the state encoding (WAIT=2'd0, HOLD=2'd1, KILL=2'd2);
  - the RESET_PC and BUBBLE_INST defaults;
  - the PC_STEP=4 constant.
- Sub-module if_inst_buf: one-entry instruction buffer with load/clear and an async reset. The FSM, PC and stale-address registers stay in the top level.

Test Plan:
- Reset, then 1-cycle memory returning 0x00500093 at 0x3000: im_req=1 with im_addr=0x3000 on the first post-reset cycle; if_valid=1 with pc_cur_out=0x3000, pc_add4_out=0x3004; next im_addr=0x3004.
- Response at 0x3004 while stall=1 for 3 cycles: state HOLD, inst_out stable, im_req=0; on stall release, accepted and next im_addr=0x3008.
- 4-cycle memory, redirect to 0x3100 two cycles into a fetch of 0x3008: im_addr stays 0x3008 until rvalid, no if_valid on that response, then im_addr=0x3100.
- Redirect to 0x3201 coincident with im_rvalid: if_valid=0 that cycle, next im_addr=0x3200.
- Redirect while in HOLD with stall=1: buffer dropped and WAIT at the target next cycle, with no valid for the old instruction.
- rst asserted mid-WAIT with no clock edge: im_req and if_valid drop immediately; after release, im_addr=0x3000.

Source files
------------

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding, reset
// defaults and the PC increment.
package if_pkg;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_HOLD = 2'd1,
    S_KILL = 2'd2
  } if_state_t;

  localparam logic [31:0] IF_RESET_PC    = 32'h0000_3000;
  localparam logic [31:0] IF_BUBBLE_INST = 32'h0000_0000;
  localparam logic [31:0] PC_STEP        = 32'd4;

  // Redirect targets are always word aligned; the low two bits are dropped.
  function automatic logic [31:0] pc_align(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_inst_buf.sv
// One-entry instruction buffer that holds a returned word while IF/ID stalls.
module if_inst_buf
  import if_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_data,
  output logic [31:0] o_data
);

  logic [31:0] r_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        r_data <= IF_BUBBLE_INST;
    else if (i_clear) r_data <= IF_BUBBLE_INST;
    else if (i_load)  r_data <= i_data;
  end

  assign o_data = r_data;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding fetches,
// buffers one instruction across stalls and squashes fetches made stale by EX.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = IF_RESET_PC,
  parameter logic [31:0] BUBBLE_INST = IF_BUBBLE_INST
) (
  input  logic        clk,
  input  logic        rst,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  input  logic        im_rvalid,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_cur_out,
  output logic [31:0] pc_add4_out,
  output logic [31:0] inst_out,
  output logic        if_valid,
  output logic        if_busy
);

  if_state_t   r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_stale_addr, w_stale_nxt;
  logic        w_buf_load, w_buf_clear;
  logic [31:0] w_buf_data;

  if_inst_buf u_buf (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_data  (im_rdata),
    .o_data  (w_buf_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_WAIT;
      r_pc         <= RESET_PC;
      r_stale_addr <= RESET_PC;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_stale_addr <= w_stale_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_stale_nxt = r_stale_addr;
    w_buf_load  = 1'b0;
    w_buf_clear = 1'b0;
    if (redirect) begin
      w_pc_nxt    = pc_align(redirect_pc);
      w_buf_clear = 1'b1;
      if (r_state == S_WAIT && !im_rvalid) begin
        w_state_nxt = S_KILL;
        w_stale_nxt = r_pc;
      end else if (r_state == S_KILL && !im_rvalid) begin
        w_state_nxt = S_KILL;
      end else begin
        w_state_nxt = S_WAIT;
      end
    end else begin
      case (r_state)
        S_WAIT: begin
          if (im_rvalid) begin
            if (stall) begin
              w_buf_load  = 1'b1;
              w_state_nxt = S_HOLD;
            end else begin
              w_pc_nxt = r_pc + PC_STEP;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            w_pc_nxt    = r_pc + PC_STEP;
            w_buf_clear = 1'b1;
            w_state_nxt = S_WAIT;
          end
        end
        S_KILL: begin
          if (im_rvalid) w_state_nxt = S_WAIT;
        end
        default: w_state_nxt = S_WAIT;
      endcase
    end
  end

  // Outputs are gated by rst so the request and valid drop without a clock edge.
  assign im_req   = !rst && (r_state == S_WAIT || r_state == S_KILL);
  assign im_addr  = (r_state == S_KILL) ? r_stale_addr : r_pc;
  assign if_valid = !rst && !redirect &&
                    ((r_state == S_WAIT && im_rvalid) || r_state == S_HOLD);
  assign if_busy  = !if_valid;

  assign inst_out    = !if_valid ? BUBBLE_INST :
                       (r_state == S_HOLD) ? w_buf_data : im_rdata;
  assign pc_cur_out  = if_valid ? r_pc : 32'd0;
  assign pc_add4_out = if_valid ? (r_pc + PC_STEP) : RESET_PC;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed, table-driven bench for if_fetch_unit; the bench plays the
// instruction memory and EX stage cycle by cycle.
module tb_if_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic        im_rvalid;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc_cur_out;
  logic [31:0] pc_add4_out;
  logic [31:0] inst_out;
  logic        if_valid;
  logic        if_busy;

  int n_pass  = 0;
  int n_total = 0;

  if_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_rdata    (im_rdata),
    .im_rvalid   (im_rvalid),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc_cur_out  (pc_cur_out),
    .pc_add4_out (pc_add4_out),
    .inst_out    (inst_out),
    .if_valid    (if_valid),
    .if_busy     (if_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic        rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic st, input logic rd, input logic [31:0] rpc,
                             input logic rv, input logic [31:0] rdata,
                             input logic e_req, input logic [31:0] e_addr,
                             input logic e_val, input logic [31:0] e_inst,
                             input logic [31:0] e_pc);
    vec_t r;
    r.st = st; r.rd = rd; r.rpc = rpc; r.rv = rv; r.rdata = rdata;
    r.e_req = e_req; r.e_addr = e_addr; r.e_val = e_val;
    r.e_inst = e_inst; r.e_pc = e_pc;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic check_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic e_val, input logic [31:0] e_inst,
                            input logic [31:0] e_pc);
    check({tag, ".im_req"}, {31'd0, im_req}, {31'd0, e_req});
    if (e_req) check({tag, ".im_addr"}, im_addr, e_addr);
    check({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, e_val});
    check({tag, ".if_busy"}, {31'd0, if_busy}, {31'd0, !e_val});
    check({tag, ".inst_out"}, inst_out, e_inst);
    check({tag, ".pc_cur"}, pc_cur_out, e_val ? e_pc : 32'd0);
    check({tag, ".pc_add4"}, pc_add4_out, e_val ? e_pc + 32'd4 : RPC);
  endtask

  initial begin
    rst = 1'b1; im_rdata = '0; im_rvalid = 1'b0; stall = 1'b0;
    redirect = 1'b0; redirect_pc = '0;

    // 1-cycle memory, fetch at 0x3000 then 0x3004 stalled for 3 cycles
    tbl.push_back(v(0,0,0,           0,0,            1,32'h3000,0,0,0));
    tbl.push_back(v(0,0,0,           1,32'h00500093, 1,32'h3000,1,32'h00500093,32'h3000));
    tbl.push_back(v(0,0,0,           0,0,            1,32'h3004,0,0,0));
    tbl.push_back(v(1,0,0,           1,32'h11111111, 1,32'h3004,1,32'h11111111,32'h3004));
    tbl.push_back(v(1,0,0,           0,0,            0,0,       1,32'h11111111,32'h3004));
    tbl.push_back(v(1,0,0,           0,0,            0,0,       1,32'h11111111,32'h3004));
    tbl.push_back(v(0,0,0,           0,0,            0,0,       1,32'h11111111,32'h3004));
    // 4-cycle memory at 0x3008, redirect to 0x3100 two cycles in
    tbl.push_back(v(0,0,0,           0,0,            1,32'h3008,0,0,0));
    tbl.push_back(v(0,0,0,           0,0,            1,32'h3008,0,0,0));
    tbl.push_back(v(0,1,32'h3100,    0,0,            1,32'h3008,0,0,0));
    tbl.push_back(v(0,0,0,           0,0,            1,32'h3008,0,0,0));
    tbl.push_back(v(0,0,0,           1,32'h22222222, 1,32'h3008,0,0,0));
    // redirect to 0x3201 coincident with rvalid
    tbl.push_back(v(0,0,0,           0,0,            1,32'h3100,0,0,0));
    tbl.push_back(v(0,1,32'h3201,    1,32'h33333333, 1,32'h3100,0,0,0));
    // redirect while holding under stall
    tbl.push_back(v(0,0,0,           0,0,            1,32'h3200,0,0,0));
    tbl.push_back(v(1,0,0,           1,32'h44444444, 1,32'h3200,1,32'h44444444,32'h3200));
    tbl.push_back(v(1,1,32'h3300,    0,0,            0,0,       0,0,0));
    tbl.push_back(v(1,0,0,           0,0,            1,32'h3300,0,0,0));
    tbl.push_back(v(0,0,0,           1,32'h55555555, 1,32'h3300,1,32'h55555555,32'h3300));
    // repeated redirects while killing, last one coincident with rvalid
    tbl.push_back(v(0,1,32'h3400,    0,0,            1,32'h3304,0,0,0));
    tbl.push_back(v(0,1,32'h3500,    0,0,            1,32'h3304,0,0,0));
    tbl.push_back(v(0,0,0,           0,0,            1,32'h3304,0,0,0));
    tbl.push_back(v(0,1,32'h3600,    1,32'h99999999, 1,32'h3304,0,0,0));
    tbl.push_back(v(0,0,0,           0,0,            1,32'h3600,0,0,0));
    tbl.push_back(v(0,0,0,           1,32'h66666666, 1,32'h3600,1,32'h66666666,32'h3600));
    // wrap: target 0xFFFFFFFF aligns to 0xFFFFFFFC, next fetch wraps to 0
    tbl.push_back(v(0,1,32'hFFFFFFFF,0,0,            1,32'h3604,0,0,0));
    tbl.push_back(v(0,0,0,           1,32'hAAAAAAAA, 1,32'h3604,0,0,0));
    tbl.push_back(v(0,0,0,           0,0,            1,32'hFFFFFFFC,0,0,0));
    tbl.push_back(v(0,0,0,           1,32'h77777777, 1,32'hFFFFFFFC,1,32'h77777777,32'hFFFFFFFC));
    tbl.push_back(v(0,0,0,           0,0,            1,32'h0,   0,0,0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      stall = tbl[i].st; redirect = tbl[i].rd; redirect_pc = tbl[i].rpc;
      im_rvalid = tbl[i].rv; im_rdata = tbl[i].rdata;
      #1;
      check_outs($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr,
                 tbl[i].e_val, tbl[i].e_inst, tbl[i].e_pc);
      @(negedge clk);
    end

    // async reset mid-WAIT while a response is being presented
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    im_rvalid = 1'b1; im_rdata = 32'h88888888;
    #1;
    check_outs("pre_rst", 1'b1, 32'h0, 1'b1, 32'h88888888, 32'h0);
    #1 rst = 1'b1;
    #1;
    im_rvalid = 1'b0; im_rdata = '0;
    check_outs("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outs("post_rst", 1'b1, RPC, 1'b0, 32'h0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
